rock_sequencer: RTL and testbench

- Closed-loop controller that sequences the cradle rocking motor from the 3-bit baby stress level and the stress-delta flags (gedaald = stress dropped, gelijk = stress equal on two consecutive clocks).
- Starts rocking when stress appears and holds each rocking mode for a settle period.
- After each settle period it evaluates the next stress sample and keeps, advances or reverts the mode; it stops the motor once the baby is calm.
- Sits between the stress-delta detector and the motor driver.

---
 rtl/rock_sequencer.sv | 113 +++++++++++
 tb/tb_rock_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rock_sequencer.sv
// rtl/rock_sequencer.sv - closed-loop cradle rocking mode sequencer
module rock_sequencer #(
   parameter int SETTLE_CYC = 1000,
   parameter int MAX_MODE   = 7,
   parameter int CALM_CNT   = 4,
   parameter int ALARM_CNT  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sample,
   input  logic [2:0] status,
   input  logic       gedaald,
   input  logic       gelijk,
   output logic       motor_en,
   output logic [2:0] mode,
   output logic       alarm,
   output logic [1:0] state
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] EVAL   = 2'd2;

   localparam logic [15:0] RELOAD    = 16'(SETTLE_CYC - 1);
   localparam logic [2:0]  MODE_MAX  = 3'(MAX_MODE);
   localparam logic [3:0]  CALM_LIM  = 4'(CALM_CNT);
   localparam logic [3:0]  ALARM_LIM = 4'(ALARM_CNT);

   logic [2:0]  best_mode;
   logic [15:0] timer;
   logic [3:0]  calm;
   logic [3:0]  hot;
   logic [2:0]  last_status;
   logic [3:0]  calm_inc;
   logic [3:0]  hot_inc;

   assign calm_inc = calm + 4'd1;
   assign hot_inc  = (hot == 4'hf) ? 4'hf : hot + 4'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         motor_en    <= 1'b0;
         mode        <= 3'd0;
         alarm       <= 1'b0;
         best_mode   <= 3'd1;
         timer       <= 16'd0;
         calm        <= 4'd0;
         hot         <= 4'd0;
         last_status <= 3'd0;
      end else begin
         if (sample)
            last_status <= status;
         case (state)
            IDLE: begin
               motor_en <= 1'b0;
               mode     <= 3'd0;
               if (sample && status != 3'd0) begin
                  state    <= SETTLE;
                  mode     <= best_mode;
                  motor_en <= 1'b1;
                  timer    <= RELOAD;
                  calm     <= 4'd0;
                  hot      <= 4'd0;
               end
            end
            SETTLE: begin
               // a strobe landing on the expiry clock is deliberately dropped
               if (timer == 16'd0)
                  state <= EVAL;
               else
                  timer <= timer - 16'd1;
            end
            EVAL: begin
               if (sample) begin
                  state <= SETTLE;
                  timer <= RELOAD;
                  if (status == 3'd0) begin
                     hot <= 4'd0;
                     if (calm_inc == CALM_LIM) begin
                        state    <= IDLE;
                        motor_en <= 1'b0;
                        mode     <= 3'd0;
                        alarm    <= 1'b0;
                        calm     <= 4'd0;
                     end else begin
                        calm <= calm_inc;
                     end
                  end else if (status == 3'd7) begin
                     calm <= 4'd0;
                     hot  <= hot_inc;
                     mode <= MODE_MAX;
                     if (hot_inc >= ALARM_LIM)
                        alarm <= 1'b1;
                  end else begin
                     calm <= 4'd0;
                     hot  <= 4'd0;
                     // last_status still holds the previous sample here
                     if (gedaald)
                        best_mode <= mode;
                     else if (gelijk)
                        mode <= (mode == MODE_MAX) ? 3'd1 : mode + 3'd1;
                     else if (status > last_status)
                        mode <= best_mode;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rock_sequencer.sv
// tb/tb_rock_sequencer.sv - directed vector bench for rock_sequencer
module tb_rock_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sample = 1'b0;
   logic [2:0] status = 3'd0;
   logic       gedaald = 1'b0;
   logic       gelijk = 1'b0;
   logic       motor_en;
   logic [2:0] mode;
   logic       alarm;
   logic [1:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   rock_sequencer #(
      .SETTLE_CYC(10),
      .MAX_MODE  (7),
      .CALM_CNT  (4),
      .ALARM_CNT (3)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sample  (sample),
      .status  (status),
      .gedaald (gedaald),
      .gelijk  (gelijk),
      .motor_en(motor_en),
      .mode    (mode),
      .alarm   (alarm),
      .state   (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         idle;
      logic [2:0] st;
      bit         ged;
      bit         gel;
      logic [1:0] e_state;
      logic [2:0] e_mode;
      bit         e_motor;
      bit         e_alarm;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input int es, input int em, input int emo, input int ea);
      chk({tag, " state"}, int'(state), es);
      chk({tag, " mode"}, int'(mode), em);
      chk({tag, " motor_en"}, int'(motor_en), emo);
      chk({tag, " alarm"}, int'(alarm), ea);
   endtask

   task automatic wait_eval(input string tag);
      int n = 0;
      while (state != 2'd2 && n < 20) begin
         edge1();
         n++;
      end
      chk({tag, " settle clocks"}, n, 10);
   endtask

   task automatic strobe(input logic [2:0] st, input bit ged, input bit gel);
      sample  = 1'b1;
      status  = st;
      gedaald = ged;
      gelijk  = gel;
      edge1();
      sample  = 1'b0;
      gedaald = 1'b0;
      gelijk  = 1'b0;
   endtask

   initial begin
      // idle, status, gedaald, gelijk -> state, mode, motor_en, alarm
      tbl.push_back('{0, 3'd3, 0, 1, 2'd1, 3'd2, 1, 0});
      tbl.push_back('{0, 3'd2, 1, 0, 2'd1, 3'd2, 1, 0});
      tbl.push_back('{0, 3'd2, 0, 1, 2'd1, 3'd3, 1, 0});
      tbl.push_back('{0, 3'd4, 0, 0, 2'd1, 3'd2, 1, 0});
      tbl.push_back('{0, 3'd4, 0, 0, 2'd1, 3'd2, 1, 0});
      tbl.push_back('{0, 3'd4, 0, 1, 2'd1, 3'd3, 1, 0});
      tbl.push_back('{0, 3'd4, 0, 1, 2'd1, 3'd4, 1, 0});
      tbl.push_back('{0, 3'd4, 0, 1, 2'd1, 3'd5, 1, 0});
      tbl.push_back('{0, 3'd4, 0, 1, 2'd1, 3'd6, 1, 0});
      tbl.push_back('{0, 3'd4, 0, 1, 2'd1, 3'd7, 1, 0});
      tbl.push_back('{0, 3'd4, 0, 1, 2'd1, 3'd1, 1, 0});
      tbl.push_back('{0, 3'd0, 0, 0, 2'd1, 3'd1, 1, 0});
      tbl.push_back('{0, 3'd0, 0, 0, 2'd1, 3'd1, 1, 0});
      tbl.push_back('{0, 3'd1, 0, 0, 2'd1, 3'd2, 1, 0});
      tbl.push_back('{0, 3'd0, 0, 0, 2'd1, 3'd2, 1, 0});
      tbl.push_back('{0, 3'd0, 0, 0, 2'd1, 3'd2, 1, 0});
      tbl.push_back('{0, 3'd0, 0, 0, 2'd1, 3'd2, 1, 0});
      tbl.push_back('{0, 3'd0, 0, 0, 2'd0, 3'd0, 0, 0});
      tbl.push_back('{1, 3'd0, 0, 0, 2'd0, 3'd0, 0, 0});
      tbl.push_back('{1, 3'd7, 0, 0, 2'd1, 3'd2, 1, 0});
      tbl.push_back('{0, 3'd7, 0, 0, 2'd1, 3'd7, 1, 0});
      tbl.push_back('{0, 3'd7, 0, 0, 2'd1, 3'd7, 1, 0});
      tbl.push_back('{0, 3'd7, 0, 0, 2'd1, 3'd7, 1, 1});
      tbl.push_back('{0, 3'd2, 1, 0, 2'd1, 3'd7, 1, 1});
      tbl.push_back('{0, 3'd0, 0, 0, 2'd1, 3'd7, 1, 1});
      tbl.push_back('{0, 3'd0, 0, 0, 2'd1, 3'd7, 1, 1});
      tbl.push_back('{0, 3'd0, 0, 0, 2'd1, 3'd7, 1, 1});
      tbl.push_back('{0, 3'd0, 0, 0, 2'd0, 3'd0, 0, 0});

      repeat (3) edge1();
      chk_out("reset", 0, 0, 0, 0);
      reset = 1'b1;
      edge1();
      chk_out("post-release", 0, 0, 0, 0);

      strobe(3'd3, 0, 0);
      chk_out("start", 1, 1, 1, 0);

      foreach (tbl[i]) begin
         string tag;
         tag = $sformatf("v%0d", i);
         if (!tbl[i].idle)
            wait_eval(tag);
         strobe(tbl[i].st, tbl[i].ged, tbl[i].gel);
         chk_out(tag, int'(tbl[i].e_state), int'(tbl[i].e_mode), int'(tbl[i].e_motor), int'(tbl[i].e_alarm));
      end

      // best_mode is 7 from the gedaald in the alarm run
      strobe(3'd5, 0, 0);
      chk_out("restart", 1, 7, 1, 0);
      repeat (3) edge1();
      #2;
      reset = 1'b0;
      #1;
      chk_out("async reset", 0, 0, 0, 0);
      #2;
      reset = 1'b1;
      edge1();
      strobe(3'd5, 0, 0);
      chk_out("after reset", 1, 1, 1, 0);

      // strobe coinciding with timer expiry must not be evaluated
      repeat (9) edge1();
      chk("pre-expiry state", int'(state), 1);
      strobe(3'd7, 0, 0);
      chk_out("expiry strobe", 2, 1, 1, 0);
      repeat (3) edge1();
      chk_out("eval hold", 2, 1, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
